rst_release_sequencer: RTL

//  Generates the active-low RN inputs for the async-reset flops (dffrnq family) in downstream domains.

---
 rtl/rst_release_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rst_release_sequencer.sv
// rst_release_sequencer
//   Builds the active-low RN inputs for the async-reset flops in the downstream
//   domains. Every output is forced low at once, with no clock, while the raw pin
//   reset RN is low. After RN rises, the outputs are released in step with CLK.
//   Release follows a hold period. Domains are then released one at a time, in
//   index order.
//   A synchronous software request (SW_RST_REQ) restarts the hold/stage sequence.
//   It does not restart the release synchroniser.
//
// Ports
//   CLK         in   1            clock, rising edge
//   RN          in   1            raw asynchronous active-low reset pin
//   SW_RST_REQ  in   1            synchronous software reset request (level)
//   RN_OUT      out  NUM_DOMAINS  per-domain active-low reset, async assert / sync release
//   DONE        out  1            all domains released
//   CAUSE_SW    out  1            most recent sequence was started by SW_RST_REQ
module rst_release_sequencer #(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   CLK,
  input  logic                   RN,
  input  logic                   SW_RST_REQ,
  output logic [NUM_DOMAINS-1:0] RN_OUT,
  output logic                   DONE,
  output logic                   CAUSE_SW
);

  localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  // Wide enough to hold NUM_DOMAINS itself, the index value after the last release.
  localparam int unsigned IDX_W   = $clog2(NUM_DOMAINS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  // Parameter sanity
  if (NUM_DOMAINS < 1) begin : g_chk_domains
    $error("rst_release_sequencer: NUM_DOMAINS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("rst_release_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("rst_release_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_chk_gap
    $error("rst_release_sequencer: GAP_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_CNT)) begin : g_chk_cnt
    $error("rst_release_sequencer: CNT_W too narrow for HOLD_CYCLES/GAP_CYCLES");
  end

  // Release synchroniser: shifts in a constant 1 and is cleared only by RN.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // Release sequencer
  typedef enum logic [1:0] {
    S_HOLD,
    S_STAGE,
    S_DONE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       dom_idx;
  logic [NUM_DOMAINS-1:0] rn_q;
  logic                   done_q;
  logic                   cause_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state   <= S_HOLD;
      cnt     <= '0;
      dom_idx <= '0;
      rn_q    <= '0;
      done_q  <= 1'b0;
      cause_q <= 1'b0;
    end else if (SW_RST_REQ) begin
      // The software request overrides any counting or release that would happen on this edge.
      state   <= S_HOLD;
      cnt     <= '0;
      dom_idx <= '0;
      rn_q    <= '0;
      done_q  <= 1'b0;
      cause_q <= 1'b1;
    end else begin
      case (state)
        S_HOLD: begin
          // The hold count starts only once the synchroniser has released.
          if (rst_sync) begin
            if (cnt == HOLD_LAST) begin
              rn_q[0] <= 1'b1;
              cnt     <= '0;
              dom_idx <= IDX_W'(1);
              if (NUM_DOMAINS == 1) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                state <= S_STAGE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_STAGE: begin
          if (cnt == GAP_LAST) begin
            for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
              if (dom_idx == IDX_W'(d)) begin
                rn_q[d] <= 1'b1;
              end
            end
            dom_idx <= dom_idx + 1'b1;
            cnt     <= '0;
            if (dom_idx == LAST_IDX) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          // Stay here until RN or SW_RST_REQ.
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

  assign RN_OUT   = rn_q;
  assign DONE     = done_q;
  assign CAUSE_SW = cause_q;

endmodule
